// File: rtl/tdm_mux_n.sv
// N-channel registered multiplexer with a manual select mode and a time-division
// scan mode that dwells DWELL cycles on each channel enabled in ch_mask.
module tdm_mux_n #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int DWELL = 4,
  localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH-1:0]         ch_mask,
  input  logic [N_CH*WIDTH-1:0]   din,
  output logic [WIDTH-1:0]        dout,
  output logic [SEL_W-1:0]        dout_ch,
  output logic                    dout_valid,
  output logic                    ch_start
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_MAN   = 2'd0,
    S_SCAN  = 2'd1,
    S_EMPTY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [SEL_W-1:0]  dout_ch_q, dout_ch_d;
  logic              dout_valid_q, dout_valid_d;
  logic              ch_start_q, ch_start_d;

  logic [WIDTH-1:0]  din_a [N_CH];
  logic              sel_ok_s;
  logic              mask_any_s;

  // Channel after idx in index order, wrapping at N_CH-1.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    return (int'(idx) >= N_CH - 1) ? SEL_ZERO : idx + 1'b1;
  endfunction

  // First enabled channel at or above start, wrapping; out-of-range start searches from 0.
  function automatic logic [SEL_W-1:0] find_from(input logic [N_CH-1:0] mask,
                                                 input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] hi;
    logic [SEL_W-1:0] lo;
    logic             hit;
    int               s;
    s   = (int'(start) < N_CH) ? int'(start) : 0;
    hi  = SEL_ZERO;
    lo  = SEL_ZERO;
    hit = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      lo  = mask[i] ? SEL_W'(i) : lo;
      hi  = (mask[i] && (i >= s)) ? SEL_W'(i) : hi;
      hit = (mask[i] && (i >= s)) ? 1'b1 : hit;
    end
    return hit ? hi : lo;
  endfunction

  // Unpack the flat channel bus into an indexable array.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      din_a[i] = din[i*WIDTH +: WIDTH];
    end
  end

  assign sel_ok_s   = (int'(sel) < N_CH);
  assign mask_any_s = (ch_mask != {N_CH{1'b0}});

  // Next-state and next-output decode; priority is en, then mode, then mask, then dwell.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = 1'b0;
    ch_start_d   = 1'b0;

    if (!en) begin
      dout_valid_d = 1'b0;
    end else if (!mode) begin
      state_d   = S_MAN;
      cnt_d     = CNT_ZERO;
      dout_ch_d = sel;
      if (sel_ok_s) begin
        dout_d       = din_a[sel];
        dout_valid_d = 1'b1;
        // A new visit starts on a channel change or after any gap in valid manual output.
        ch_start_d   = (sel != dout_ch_q) || !dout_valid_q || (state_q != S_MAN);
      end else begin
        dout_d       = {WIDTH{1'b0}};
        dout_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_MAN: begin
          cnt_d = CNT_ZERO;
          if (mask_any_s) begin
            state_d = S_SCAN;
            cur_d   = find_from(ch_mask, sel);
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_SCAN: begin
          if (!mask_any_s) begin
            state_d = S_EMPTY;
          end else if (!ch_mask[cur_q]) begin
            // Current channel was withdrawn: skip it without emitting a sample.
            cur_d = find_from(ch_mask, wrap_inc(cur_q));
            cnt_d = CNT_ZERO;
          end else begin
            dout_d       = din_a[cur_q];
            dout_ch_d    = cur_q;
            dout_valid_d = 1'b1;
            ch_start_d   = (cnt_q == CNT_ZERO);
            if (cnt_q == CNT_LAST) begin
              cnt_d = CNT_ZERO;
              cur_d = find_from(ch_mask, wrap_inc(cur_q));
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_EMPTY: begin
          if (mask_any_s) begin
            state_d = S_SCAN;
            cur_d   = find_from(ch_mask, cur_q);
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = S_EMPTY;
          end
        end
        default: begin
          state_d = S_MAN;
          cur_d   = SEL_ZERO;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_MAN;
      cur_q        <= SEL_ZERO;
      cnt_q        <= CNT_ZERO;
      dout_q       <= {WIDTH{1'b0}};
      dout_ch_q    <= SEL_ZERO;
      dout_valid_q <= 1'b0;
      ch_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      ch_start_q   <= ch_start_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign ch_start   = ch_start_q;

endmodule

// File: tb/tb_tdm_mux_n.sv
// Directed bench for tdm_mux_n (N_CH=4, WIDTH=8, DWELL=4); outputs are sampled
// on the falling edge, inputs change on the falling edge.
module tb_tdm_mux_n;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  ch_mask;
  logic [31:0] din;
  logic [7:0]  dout;
  logic [1:0]  dout_ch;
  logic        dout_valid;
  logic        ch_start;

  int total;
  int bad;

  tdm_mux_n #(.N_CH(4), .WIDTH(8), .DWELL(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .sel        (sel),
    .ch_mask    (ch_mask),
    .din        (din),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .ch_start   (ch_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] c,
                         input logic v, input logic s);
    chk({tag, ".dout"}, dout, d);
    chk({tag, ".ch"}, {6'd0, dout_ch}, {6'd0, c});
    chk({tag, ".valid"}, {7'd0, dout_valid}, {7'd0, v});
    chk({tag, ".start"}, {7'd0, ch_start}, {7'd0, s});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    int         ch;
    int         k;
    int         sp [3];
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    en      = 1'b1;
    mode    = 1'b0;
    sel     = 2'd2;
    ch_mask = 4'b0000;
    din     = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset then manual
    tick();
    chk_out("rst", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("rst2", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("man_sel2", 8'h33, 2'd2, 1'b1, 1'b1);
    tick();
    chk_out("man_sel2_hold", 8'h33, 2'd2, 1'b1, 1'b0);
    sel = 2'd0;
    tick();
    chk_out("man_sel0", 8'h11, 2'd0, 1'b1, 1'b1);

    // Scan with full mask starting at sel=0
    mode    = 1'b1;
    ch_mask = 4'b1111;
    tick();
    chk_out("scan_entry", 8'h11, 2'd0, 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        e = 8'(8'h11 * (g + 1));
        chk_out($sformatf("scan_g%0d_k%0d", g, j), e, 2'(g), 1'b1, (j == 0));
      end
    end
    tick();
    chk_out("scan_wrap", 8'h11, 2'd0, 1'b1, 1'b1);

    // Sparse mask: channel 0 withdrawn mid-dwell, then 1,3,1
    ch_mask = 4'b1010;
    tick();
    chk_out("sparse_drop", 8'h11, 2'd0, 1'b0, 1'b0);
    sp = '{1, 3, 1};
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        e = 8'(8'h11 * (sp[g] + 1));
        chk_out($sformatf("sparse_g%0d_k%0d", g, j), e, 2'(sp[g]), 1'b1, (j == 0));
      end
    end

    // Back to manual on ch1, then scan 0110 and drop ch1 on its third dwell cycle
    mode = 1'b0;
    sel  = 2'd1;
    tick();
    chk_out("man_from_scan", 8'h22, 2'd1, 1'b1, 1'b1);
    mode    = 1'b1;
    ch_mask = 4'b0110;
    tick();
    chk_out("drop_entry", 8'h22, 2'd1, 1'b0, 1'b0);
    tick();
    chk_out("drop_c0", 8'h22, 2'd1, 1'b1, 1'b1);
    tick();
    chk_out("drop_c1", 8'h22, 2'd1, 1'b1, 1'b0);
    ch_mask = 4'b0100;
    tick();
    chk_out("drop_gap", 8'h22, 2'd1, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_out($sformatf("drop_ch2_k%0d", j), 8'h33, 2'd2, 1'b1, (j == 0));
    end
    ch_mask = 4'b0000;
    tick();
    chk_out("empty0", 8'h33, 2'd2, 1'b0, 1'b0);
    tick();
    chk_out("empty1", 8'h33, 2'd2, 1'b0, 1'b0);
    ch_mask = 4'b0100;
    tick();
    chk_out("empty_exit", 8'h33, 2'd2, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_out($sformatf("resume_k%0d", j), 8'h33, 2'd2, 1'b1, (j == 0));
    end

    // Enable gating for 3 cycles in the middle of a ch2 dwell
    ch_mask = 4'b1111;
    tick();
    chk_out("en_c0", 8'h33, 2'd2, 1'b1, 1'b1);
    tick();
    chk_out("en_c1", 8'h33, 2'd2, 1'b1, 1'b0);
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_out($sformatf("en_off%0d", j), 8'h33, 2'd2, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick();
    chk_out("en_c2", 8'h33, 2'd2, 1'b1, 1'b0);
    tick();
    chk_out("en_c3", 8'h33, 2'd2, 1'b1, 1'b0);
    tick();
    chk_out("en_next", 8'h44, 2'd3, 1'b1, 1'b1);

    // Run on to the start of the next ch2 dwell
    for (int t = 0; t < 11; t++) begin
      ch = (3 + (t + 1) / 4) % 4;
      k  = (t + 1) % 4;
      tick();
      e = 8'(8'h11 * (ch + 1));
      chk_out($sformatf("run_t%0d", t), e, 2'(ch), 1'b1, (k == 0));
    end
    tick();
    chk_out("pre_arst", 8'h33, 2'd2, 1'b1, 1'b1);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk_out("arst_async", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("arst_held", 8'h00, 2'd0, 1'b0, 1'b0);
    mode    = 1'b1;
    sel     = 2'd1;
    ch_mask = 4'b1111;
    rst     = 1'b0;
    tick();
    chk_out("arst_entry", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    chk_out("arst_c0", 8'h22, 2'd1, 1'b1, 1'b1);
    tick();
    chk_out("arst_c1", 8'h22, 2'd1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
